// File: rtl/mess_counter_arbiter_pkg.sv
// Shared types for the meal-counter arbiter: FSM states, ALU action encodings
// and the default number of kiosks.
package mess_pkg;

    localparam int DEFAULT_NUM_PORTS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_CHECK,
        ST_COMMIT,
        ST_RESP
    } state_t;

    typedef logic [1:0] action_t;

    localparam action_t ACT_NONE    = 2'b00;
    localparam action_t ACT_DEBIT   = 2'b01;
    localparam action_t ACT_REFUND  = 2'b10;
    localparam action_t ACT_BALANCE = 2'b11;

endpackage

// File: rtl/mess_counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible port at or after ptr,
// wrapping around NUM_PORTS.
module rr_arbiter
    import mess_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] win_onehot,
    output logic [PORT_W-1:0]    win_idx,
    output logic                 win_valid
);

    int idx;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        idx        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!win_valid && eligible[idx]) begin
                win_valid       = 1'b1;
                win_idx         = idx[PORT_W-1:0];
                win_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mess_counter_arbiter.sv
// Shares the ALU / credit-register datapath between meal counters: round-robin
// pick, credit check, single load strobe, then a one-cycle ack or deny.
module mess_counter_arbiter
    import mess_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int PORT_W    = 2,
    parameter int TXN_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [2*NUM_PORTS-1:0] action_in,
    input  logic                   credit_ok,
    output logic [1:0]             alu_action,
    output logic                   load_enable,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [NUM_PORTS-1:0]   ack,
    output logic [NUM_PORTS-1:0]   deny,
    output logic                   busy,
    output logic [PORT_W-1:0]      active_port,
    output logic [TXN_W-1:0]       txn_count
);

    state_t                state_q, state_d;
    logic [PORT_W-1:0]     ptr_q;
    logic [PORT_W-1:0]     win_q;
    logic [NUM_PORTS-1:0]  mask_q;
    logic [NUM_PORTS-1:0]  own_q;
    action_t               act_q;
    logic                  ack_pend_q;
    logic [TXN_W-1:0]      txn_q;

    logic [NUM_PORTS-1:0]  arb_onehot;
    logic [PORT_W-1:0]     arb_idx;
    logic                  arb_valid;
    logic                  owner_req;
    logic                  take;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr (
        .eligible   (req & ~mask_q),
        .ptr        (ptr_q),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .win_valid  (arb_valid)
    );

    assign owner_req   = |(own_q & req);
    assign take        = (state_q == ST_IDLE) && arb_valid;
    assign busy        = (state_q != ST_IDLE);
    assign active_port = win_q;
    assign txn_count   = txn_q;

    always_comb begin
        state_d     = state_q;
        grant       = '0;
        ack         = '0;
        deny        = '0;
        load_enable = 1'b0;
        alu_action  = ACT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                grant      = own_q;
                alu_action = act_q;
                state_d    = owner_req ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                grant      = own_q;
                alu_action = act_q;
                if (!owner_req)     state_d = ST_IDLE;
                else if (credit_ok) state_d = ST_COMMIT;
                else                state_d = ST_RESP;
            end
            // Past the credit check the debit is committed regardless of req.
            ST_COMMIT: begin
                grant       = own_q;
                alu_action  = act_q;
                load_enable = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                ack     = ack_pend_q ? own_q : '0;
                deny    = ack_pend_q ? '0 : own_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            mask_q     <= '0;
            ack_pend_q <= 1'b0;
            txn_q      <= '0;
        end else begin
            state_q <= state_d;
            // A served port stays masked until it lowers req, so a held req
            // cannot be debited twice.
            mask_q  <= (mask_q & req) | ((state_q == ST_RESP) ? (own_q & req) : '0);
            if (take) begin
                win_q <= arb_idx;
                ptr_q <= (arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state_q == ST_CHECK) ack_pend_q <= credit_ok;
            if ((state_q == ST_COMMIT) && (txn_q != {TXN_W{1'b1}})) txn_q <= txn_q + 1'b1;
        end
    end

    // Owner vector and action are only observed while gated by state.
    always_ff @(posedge clk) begin
        if (take) begin
            own_q <= arb_onehot;
            act_q <= action_in[{arb_idx, 1'b0} +: 2];
        end
    end

endmodule

// File: tb/tb_mess_counter_arbiter.sv
// Directed bench for mess_counter_arbiter: latency, round-robin order, deny,
// abort, async reset mid-commit and counter saturation.
module tb_mess_counter_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] action_in;
    logic       credit_ok;
    logic [1:0] alu_action;
    logic       load_enable;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [3:0] deny;
    logic       busy;
    logic [1:0] active_port;
    logic [7:0] txn_count;

    int n_checks = 0;
    int n_err    = 0;

    mess_counter_arbiter #(
        .NUM_PORTS (4),
        .PORT_W    (2),
        .TXN_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .action_in   (action_in),
        .credit_ok   (credit_ok),
        .alu_action  (alu_action),
        .load_enable (load_enable),
        .grant       (grant),
        .ack         (ack),
        .deny        (deny),
        .busy        (busy),
        .active_port (active_port),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wait_grant(input int limit, output logic [3:0] g);
        g = 4'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (grant != 4'b0) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int limit, output int loads,
                             output logic [3:0] a, output logic [3:0] d);
        loads = 0;
        a     = 4'b0;
        d     = 4'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (load_enable) loads++;
            if ((ack | deny) != 4'b0) begin
                a = ack;
                d = deny;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g, a, d;
        logic [3:0] order [5];
        int         loads;
        int         acks;

        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst = 1'b1; req = 4'b0; action_in = 8'h00; credit_ok = 1'b0;
        repeat (2) nxt();
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_deny", deny, 0);
        chk("rst_load", load_enable, 0);
        chk("rst_alu", alu_action, 0);
        chk("rst_active", active_port, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_count, 0);
        rst = 1'b0;
        nxt();

        // single debit on port 0, exact latency
        req = 4'b0001; action_in = 8'h01; credit_ok = 1'b1;
        nxt();
        chk("t1_grant_n1", grant, 4'b0001);
        chk("t1_alu_n1", alu_action, 2'b01);
        chk("t1_load_n1", load_enable, 0);
        chk("t1_busy_n1", busy, 1);
        action_in = 8'h03;
        nxt();
        chk("t1_grant_n2", grant, 4'b0001);
        chk("t1_alu_latched", alu_action, 2'b01);
        chk("t1_load_n2", load_enable, 0);
        nxt();
        chk("t1_grant_n3", grant, 4'b0001);
        chk("t1_load_n3", load_enable, 1);
        nxt();
        chk("t1_ack_n4", ack, 4'b0001);
        chk("t1_grant_n4", grant, 0);
        chk("t1_load_n4", load_enable, 0);
        chk("t1_txn", txn_count, 1);
        req = 4'b0;
        nxt();
        chk("t1_ack_done", ack, 0);
        chk("t1_idle", busy, 0);

        // round robin with all ports requesting, each releasing after its ack
        rst = 1'b1; nxt();
        chk("t2_rst_txn", txn_count, 0);
        rst = 1'b0; nxt();
        req = 4'b1111; action_in = 8'h55; credit_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(12, g);
            chk("t2_grant_order", g, order[k]);
            wait_resp(8, loads, a, d);
            chk("t2_loads", loads, 1);
            chk("t2_ack", a, order[k]);
            nxt();
            req = req & ~a;
            if (k == 1) req[0] = 1'b1;
        end
        chk("t2_txn", txn_count, 5);
        req = 4'b0;
        nxt();

        // deny on port 2, req held afterwards must not be regranted
        req = 4'b0100; credit_ok = 1'b0;
        nxt();
        chk("t3_grant_n1", grant, 4'b0100);
        chk("t3_active", active_port, 2);
        chk("t3_load_n1", load_enable, 0);
        nxt();
        chk("t3_grant_n2", grant, 4'b0100);
        chk("t3_load_n2", load_enable, 0);
        nxt();
        chk("t3_deny", deny, 4'b0100);
        chk("t3_ack", ack, 0);
        chk("t3_load_n3", load_enable, 0);
        chk("t3_txn", txn_count, 5);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("t3_held_no_regrant", grant, 0);
        end
        req = 4'b0;
        nxt();

        // port 1 aborts during CHECK, port 2 is served next
        req = 4'b0110; action_in = 8'h24; credit_ok = 1'b1;
        nxt();
        chk("t4_grant_p1", grant, 4'b0010);
        chk("t4_alu_p1", alu_action, 2'b01);
        nxt();
        chk("t4_check_grant", grant, 4'b0010);
        chk("t4_check_load", load_enable, 0);
        req = 4'b0100;
        nxt();
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_grant", grant, 0);
        chk("t4_abort_resp", {ack, deny}, 0);
        chk("t4_abort_load", load_enable, 0);
        nxt();
        chk("t4_grant_p2", grant, 4'b0100);
        chk("t4_alu_p2", alu_action, 2'b10);
        wait_resp(8, loads, a, d);
        chk("t4_loads", loads, 1);
        chk("t4_ack", a, 4'b0100);
        chk("t4_txn", txn_count, 6);
        req = 4'b0;
        nxt();

        // async reset in the middle of COMMIT
        req = 4'b0001; action_in = 8'h01; credit_ok = 1'b1;
        nxt(); nxt(); nxt();
        chk("t5_commit_load", load_enable, 1);
        chk("t5_commit_grant", grant, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_load", load_enable, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_txn", txn_count, 0);
        chk("t5_rst_busy", busy, 0);
        nxt();
        rst = 1'b0;
        wait_grant(6, g);
        chk("t5_fresh_grant", g, 4'b0001);
        wait_resp(8, loads, a, d);
        chk("t5_fresh_loads", loads, 1);
        chk("t5_fresh_ack", a, 4'b0001);
        chk("t5_fresh_txn", txn_count, 1);
        req = 4'b0;
        nxt();

        // 260 debits: counter saturates at 255
        acks = 0;
        for (int k = 0; k < 260; k++) begin
            req = 4'b0001;
            wait_resp(10, loads, a, d);
            if (a == 4'b0001) acks++;
            req = 4'b0;
            if (k == 99)  chk("t6_txn_101", txn_count, 101);
            if (k == 253) chk("t6_txn_255", txn_count, 255);
            nxt();
        end
        chk("t6_acks", acks, 260);
        chk("t6_txn_sat", txn_count, 255);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
